// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end and the decoder.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    F_REQ   = 2'd0,
    F_WAIT  = 2'd1,
    F_HOLD  = 2'd2,
    F_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Instruction field positions, shared with the decoder
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned FUNC3_LSB  = 12;
  localparam int unsigned FUNC3_W    = 3;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNC7_LSB  = 25;
  localparam int unsigned FUNC7_W    = 7;

  // A fetch address is misaligned when it is not word aligned
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, instruction register, redirect tracking
// and a single-outstanding-request memory handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [XLEN-1:0]     imem_rsp_data,
  input  logic                pc_load,
  input  logic [XLEN-1:0]     next_pc,
  output logic [XLEN-1:0]     instr,
  output logic                instr_valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNC3_W-1:0]  func3,
  output logic [FUNC7_W-1:0]  func7,
  output logic [REG_W-1:0]    rs1,
  output logic [REG_W-1:0]    rs2,
  output logic [REG_W-1:0]    rd,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus_4,
  output logic                fetch_stall,
  output logic                instr_misaligned
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            redir_pend_q, redir_pend_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  // A pc_load coinciding with the response counts as an already-pending redirect
  logic            redir_hit;
  logic [XLEN-1:0] redir_tgt;
  assign redir_hit = redir_pend_q | pc_load;
  assign redir_tgt = pc_load ? next_pc : redir_pc_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= F_REQ;
    else     state_q <= state_d;
  end

  // Datapath registers: PC, IR, valid flag and redirect capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      redir_pend_q  <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      redir_pend_q  <= redir_pend_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    redir_pend_d  = redir_pend_q;
    redir_pc_d    = redir_pc_q;
    case (state_q)
      F_REQ: begin
        if (pc_load) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = next_pc;
        end
        if (imem_req_ready) state_d = F_WAIT;
      end
      F_WAIT: begin
        if (pc_load) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = next_pc;
        end
        if (imem_rsp_valid) begin
          if (redir_hit) begin
            pc_d         = redir_tgt;
            redir_pend_d = 1'b0;
            state_d      = is_misaligned(redir_tgt) ? F_FAULT : F_REQ;
          end else begin
            instr_d       = imem_rsp_data;
            instr_valid_d = 1'b1;
            state_d       = F_HOLD;
          end
        end
      end
      F_HOLD, F_FAULT: begin
        if (pc_load) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          state_d       = is_misaligned(next_pc) ? F_FAULT : F_REQ;
        end
      end
      default: state_d = F_REQ;
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    imem_req_valid   = 1'b0;
    fetch_stall      = 1'b0;
    instr_misaligned = 1'b0;
    case (state_q)
      F_REQ: begin
        imem_req_valid = ~rst;
        fetch_stall    = 1'b1;
      end
      F_WAIT:  fetch_stall      = 1'b1;
      F_FAULT: instr_misaligned = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus_4   = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

  assign opcode = instr_q[OPCODE_LSB +: OPCODE_W];
  assign rd     = instr_q[RD_LSB     +: REG_W];
  assign func3  = instr_q[FUNC3_LSB  +: FUNC3_W];
  assign rs1    = instr_q[RS1_LSB    +: REG_W];
  assign rs2    = instr_q[RS2_LSB    +: REG_W];
  assign func7  = instr_q[FUNC7_LSB  +: FUNC7_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change 1 time unit after the rising
// edge, outputs are sampled 2 units later within the same cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        pc_load;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] pc, pc_plus_4;
  logic        fetch_stall;
  logic        instr_misaligned;

  int passed = 0;
  int total  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pc_load(pc_load), .next_pc(next_pc),
    .instr(instr), .instr_valid(instr_valid), .opcode(opcode),
    .func3(func3), .func7(func7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .pc(pc), .pc_plus_4(pc_plus_4), .fetch_stall(fetch_stall),
    .instr_misaligned(instr_misaligned)
  );

  always #5 clk = ~clk;

  // Advance to the start of the next cycle (just after the rising edge)
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    pc_load        = 1'b0;
    next_pc        = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    adv(); adv();
    #2;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", imem_req_valid); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL rst_pc got %h want 00000000", pc); else passed++;
    total++; if (instr !== 32'h0000_0013) $display("FAIL rst_instr got %h want 00000013", instr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid got %b want 0", instr_valid); else passed++;
    total++; if (instr_misaligned !== 1'b0) $display("FAIL rst_misaligned got %b want 0", instr_misaligned); else passed++;
  endtask

  task automatic test_first_fetch();
    adv();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    #2;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL ff_req_valid got %b want 1", imem_req_valid); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL ff_addr got %h want 00000000", imem_addr); else passed++;
    adv();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00A0_0093;
    #2;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL ff_wait_req got %b want 0", imem_req_valid); else passed++;
    adv();
    imem_rsp_valid = 1'b0;
    #2;
    total++; if (instr_valid !== 1'b1) $display("FAIL ff_valid got %b want 1", instr_valid); else passed++;
    total++; if (instr !== 32'h00A0_0093) $display("FAIL ff_instr got %h want 00a00093", instr); else passed++;
    total++; if (opcode !== 7'h13) $display("FAIL ff_opcode got %h want 13", opcode); else passed++;
    total++; if (rd !== 5'd1) $display("FAIL ff_rd got %0d want 1", rd); else passed++;
    total++; if (pc_plus_4 !== 32'h4) $display("FAIL ff_pc_plus_4 got %h want 00000004", pc_plus_4); else passed++;
    total++; if (fetch_stall !== 1'b0) $display("FAIL ff_hold_stall got %b want 0", fetch_stall); else passed++;
  endtask

  task automatic test_ready_stall();
    pc_load = 1'b1;
    next_pc = 32'h100;
    adv();
    pc_load = 1'b0;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++; if (imem_req_valid !== 1'b1) $display("FAIL st_req_valid[%0d] got %b want 1", i, imem_req_valid); else passed++;
      total++; if (imem_addr !== 32'h100) $display("FAIL st_addr[%0d] got %h want 00000100", i, imem_addr); else passed++;
      total++; if (fetch_stall !== 1'b1) $display("FAIL st_stall[%0d] got %b want 1", i, fetch_stall); else passed++;
      adv();
    end
    imem_req_ready = 1'b1;
    #2;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL st_accept_valid got %b want 1", imem_req_valid); else passed++;
    adv();
    imem_req_ready = 1'b0;
    #2;
    total++; if (imem_req_valid !== 1'b0 || fetch_stall !== 1'b1) $display("FAIL st_wait got valid=%b stall=%b want 0/1", imem_req_valid, fetch_stall); else passed++;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h4020_81B3;
    adv();
    imem_rsp_valid = 1'b0;
    #2;
    total++; if (instr !== 32'h4020_81B3) $display("FAIL st_instr got %h want 402081b3", instr); else passed++;
    total++; if (func7 !== 7'h20) $display("FAIL st_func7 got %h want 20", func7); else passed++;
    total++; if (func3 !== 3'd0) $display("FAIL st_func3 got %0d want 0", func3); else passed++;
    total++; if (rs1 !== 5'd1 || rs2 !== 5'd2 || rd !== 5'd3) $display("FAIL st_regs got %0d/%0d/%0d want 1/2/3", rs1, rs2, rd); else passed++;
    total++; if (pc !== 32'h100 || pc_plus_4 !== 32'h104) $display("FAIL st_pc got %h/%h want 00000100/00000104", pc, pc_plus_4); else passed++;
  endtask

  task automatic test_redirect_hold();
    pc_load = 1'b1;
    next_pc = 32'h200;
    #2;
    total++; if (instr_valid !== 1'b1) $display("FAIL rh_valid_at_load got %b want 1", instr_valid); else passed++;
    adv();
    pc_load = 1'b0;
    imem_req_ready = 1'b1;
    #2;
    total++; if (instr_valid !== 1'b0) $display("FAIL rh_valid_drop got %b want 0", instr_valid); else passed++;
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) $display("FAIL rh_req got %b@%h want 1@00000200", imem_req_valid, imem_addr); else passed++;
    adv();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    adv();
    imem_rsp_valid = 1'b0;
    #2;
    total++; if (instr_valid !== 1'b1 || pc !== 32'h200) $display("FAIL rh_latency got %b pc %h want 1 pc 00000200", instr_valid, pc); else passed++;
  endtask

  task automatic test_misaligned();
    pc_load = 1'b1;
    next_pc = 32'h203;
    adv();
    pc_load = 1'b0;
    imem_req_ready = 1'b1;
    #2;
    total++; if (instr_misaligned !== 1'b1) $display("FAIL ma_flag got %b want 1", instr_misaligned); else passed++;
    total++; if (pc !== 32'h203) $display("FAIL ma_pc got %h want 00000203", pc); else passed++;
    total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) $display("FAIL ma_quiet got req=%b iv=%b want 0/0", imem_req_valid, instr_valid); else passed++;
    adv();
    #2;
    total++; if (imem_req_valid !== 1'b0 || instr_misaligned !== 1'b1) $display("FAIL ma_stay got req=%b mis=%b want 0/1", imem_req_valid, instr_misaligned); else passed++;
    pc_load = 1'b1;
    next_pc = 32'h80;
    adv();
    pc_load = 1'b0;
    #2;
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h80 || instr_misaligned !== 1'b0) $display("FAIL ma_recover got %b@%h mis=%b want 1@00000080 mis=0", imem_req_valid, imem_addr, instr_misaligned); else passed++;
    adv();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0113;
    adv();
    imem_rsp_valid = 1'b0;
    #2;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h0010_0113) $display("FAIL ma_fetch got %b %h want 1 00100113", instr_valid, instr); else passed++;
  endtask

  task automatic test_redirect_wait();
    pc_load = 1'b1;
    next_pc = 32'h10;
    adv();
    imem_req_ready = 1'b1;
    next_pc = 32'h30;
    adv();
    imem_req_ready = 1'b0;
    next_pc = 32'h40;
    #2;
    total++; if (fetch_stall !== 1'b1 || imem_req_valid !== 1'b0) $display("FAIL rw_wait got stall=%b req=%b want 1/0", fetch_stall, imem_req_valid); else passed++;
    adv();
    pc_load = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    adv();
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    #2;
    total++; if (instr_valid !== 1'b0) $display("FAIL rw_discard_valid got %b want 0", instr_valid); else passed++;
    total++; if (instr !== 32'h0010_0113) $display("FAIL rw_discard_instr got %h want 00100113", instr); else passed++;
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) $display("FAIL rw_req got %b@%h want 1@00000040", imem_req_valid, imem_addr); else passed++;
    adv();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00C5_8533;
    adv();
    imem_rsp_valid = 1'b0;
    #2;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h00C5_8533 || pc !== 32'h40) $display("FAIL rw_fetch got %b %h pc %h want 1 00c58533 pc 00000040", instr_valid, instr, pc); else passed++;
  endtask

  task automatic test_wrap_spurious();
    pc_load = 1'b1;
    next_pc = 32'hFFFF_FFFC;
    adv();
    pc_load = 1'b0;
    imem_req_ready = 1'b1;
    #2;
    total++; if (pc_plus_4 !== 32'h0) $display("FAIL wr_pc_plus_4 got %h want 00000000", pc_plus_4); else passed++;
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_addr got %h want fffffffc", imem_addr); else passed++;
    adv();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_006F;
    adv();
    imem_rsp_data  = 32'h1234_5678;
    #2;
    total++; if (instr !== 32'h0000_006F) $display("FAIL wr_instr got %h want 0000006f", instr); else passed++;
    adv();
    imem_rsp_valid = 1'b0;
    #2;
    total++; if (instr !== 32'h0000_006F || instr_valid !== 1'b1) $display("FAIL sp_hold got %h iv=%b want 0000006f iv=1", instr, instr_valid); else passed++;
  endtask

  task automatic test_reset_in_wait();
    pc_load = 1'b1;
    next_pc = 32'h300;
    adv();
    pc_load = 1'b0;
    imem_req_ready = 1'b1;
    adv();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hAAAA_AAAA;
    adv();
    imem_rsp_valid = 1'b0;
    #2;
    total++; if (pc !== 32'h0 || instr !== 32'h0000_0013 || instr_valid !== 1'b0) $display("FAIL rw_rst got pc %h instr %h iv %b want 00000000 00000013 0", pc, instr, instr_valid); else passed++;
    total++; if (imem_req_valid !== 1'b0 || fetch_stall !== 1'b1) $display("FAIL rw_rst_req got req=%b stall=%b want 0/1", imem_req_valid, fetch_stall); else passed++;
    adv();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5555_5555;
    #2;
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rw_restart got %b@%h want 1@00000000", imem_req_valid, imem_addr); else passed++;
    adv();
    imem_rsp_valid = 1'b0;
    #2;
    total++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b0 || imem_req_valid !== 1'b1) $display("FAIL rw_late_rsp got %h iv=%b req=%b want 00000013 0 1", instr, instr_valid, imem_req_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_ready_stall();
    test_redirect_hold();
    test_misaligned();
    test_redirect_wait();
    test_wrap_spurious();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
